// File: rtl/cpu_pkg.sv
// Shared pipeline types: load-type encodings and the M/W pipeline bundle.
package cpu_pkg;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  // load_type kept as raw bits so reserved codes can pass through to W.
  typedef struct packed {
    logic          reg_write;
    logic          mem_to_reg;
    logic [2:0]    load_type;
    logic [DW-1:0] alu_out;
    logic [AW-1:0] rw;
  } pipe_bundle_t;

  localparam pipe_bundle_t BUBBLE = '0;
endpackage

// File: rtl/mem_wb_pipe_if.sv
// E-stage inputs, data-memory port, M forwarding triple and W write port.
interface mem_wb_pipe_if #(parameter int DW = 32, parameter int AW = 5);
  logic          reg_writeE;
  logic          mem_to_regE;
  logic [2:0]    load_typeE;
  logic [DW-1:0] alu_outE;
  logic [AW-1:0] rwE;
  logic          stallM;
  logic          flushM;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] dmem_addr;
  logic          RegWriteM;
  logic [DW-1:0] Alu_outM;
  logic [AW-1:0] rwM;
  logic          load_pendingM;
  logic          we;
  logic [AW-1:0] rw;
  logic [DW-1:0] busw;
  logic          misalignW;

  modport master (
    output reg_writeE, mem_to_regE, load_typeE, alu_outE, rwE, stallM, flushM, dmem_rdata,
    input  dmem_addr, RegWriteM, Alu_outM, rwM, load_pendingM, we, rw, busw, misalignW
  );

  modport slave (
    input  reg_writeE, mem_to_regE, load_typeE, alu_outE, rwE, stallM, flushM, dmem_rdata,
    output dmem_addr, RegWriteM, Alu_outM, rwM, load_pendingM, we, rw, busw, misalignW
  );
endinterface

// File: rtl/mem_wb_pipe_load_align.sv
// Big-endian load extraction, sign/zero extension and misalign detection.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misalign
);
  logic [15:0] half;
  logic [7:0]  byte_sel;

  // Select the addressed half and byte; offset 0 is the most significant lane.
  always_comb begin
    half = offset[1] ? rdata[15:0] : rdata[31:16];
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Extend by load type; reserved codes behave as LW.
  always_comb begin
    data     = rdata;
    misalign = |offset;
    case (load_type)
      LT_LH:  begin data = {{16{half[15]}}, half};       misalign = offset[0]; end
      LT_LHU: begin data = {16'h0, half};                misalign = offset[0]; end
      LT_LB:  begin data = {{24{byte_sel[7]}}, byte_sel}; misalign = 1'b0; end
      LT_LBU: begin data = {24'h0, byte_sel};            misalign = 1'b0; end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB registers, M-stage forwarding and W-stage write port.
module mem_wb_pipe
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  mem_wb_pipe_if.slave bus
);
  pipe_bundle_t  e_d, m_q, w_q;
  logic [DW-1:0] ld_data;
  logic          ld_mis;
  logic [AW-1:0] rw_m, rw_w;
  logic          mis_w;

  assign e_d = '{reg_write:  bus.reg_writeE,
                 mem_to_reg: bus.mem_to_regE,
                 load_type:  bus.load_typeE,
                 alu_out:    bus.alu_outE,
                 rw:         bus.rwE};

  // M register: flush beats stall, stall holds, otherwise capture E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          m_q <= BUBBLE;
    else if (bus.flushM) m_q <= BUBBLE;
    else if (!bus.stallM) m_q <= e_d;
  end

  // W register: a stalled or flushed M must not retire twice, so W takes a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       w_q <= BUBBLE;
    else if (bus.stallM || bus.flushM) w_q <= BUBBLE;
    else                              w_q <= m_q;
  end

  load_align u_align (
    .load_type (w_q.load_type),
    .offset    (w_q.alu_out[1:0]),
    .rdata     (bus.dmem_rdata),
    .data      (ld_data),
    .misalign  (ld_mis)
  );

  assign rw_m = m_q.rw;
  assign rw_w = w_q.rw;

  // Loads are not forwardable from M; r0 is never a real destination.
  assign bus.RegWriteM     = m_q.reg_write & ~m_q.mem_to_reg & (rw_m != '0);
  assign bus.load_pendingM = m_q.reg_write &  m_q.mem_to_reg & (rw_m != '0);
  assign bus.Alu_outM      = m_q.alu_out;
  assign bus.rwM           = rw_m;
  assign bus.dmem_addr     = m_q.alu_out;

  assign mis_w         = w_q.mem_to_reg & w_q.reg_write & ld_mis;
  assign bus.misalignW = mis_w;
  assign bus.we        = w_q.reg_write & (rw_w != '0) & ~mis_w;
  assign bus.rw        = rw_w;
  assign bus.busw      = w_q.mem_to_reg ? ld_data : w_q.alu_out;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scenario bench for mem_wb_pipe: expected W-stage writes are queued when the
// E-stage stimulus is driven and popped when the instruction reaches W.
module tb_mem_wb_pipe;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_wb_pipe_if #(.DW(32), .AW(5)) bus ();
  mem_wb_pipe #(.DW(32), .AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        mis;
    bit          chk_busw;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic wr, input logic m2r, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [4:0] rwv);
    bus.reg_writeE  = wr;
    bus.mem_to_regE = m2r;
    bus.load_typeE  = lt;
    bus.alu_outE    = alu;
    bus.rwE         = rwv;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rwv, input logic [31:0] bw,
                          input logic mis, input bit cb);
    exp_t e;
    e.we = we; e.rw = rwv; e.busw = bw; e.mis = mis; e.chk_busw = cb;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.stallM = 1'b0; bus.flushM = 1'b0; bus.dmem_rdata = 32'hFFFF_FFFF;
    drive_e(1'b1, 1'b0, LT_LW, 32'h55, 5'd7);
    tick(); tick();
    n_chk++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL rst_RegWriteM got %b exp 0", bus.RegWriteM); end
    n_chk++; if (bus.Alu_outM !== 32'h0) begin n_fail++; $display("FAIL rst_Alu_outM got %h exp 0", bus.Alu_outM); end
    n_chk++; if (bus.rwM !== 5'd0) begin n_fail++; $display("FAIL rst_rwM got %0d exp 0", bus.rwM); end
    n_chk++; if (bus.load_pendingM !== 1'b0) begin n_fail++; $display("FAIL rst_load_pendingM got %b exp 0", bus.load_pendingM); end
    n_chk++; if ({bus.we, bus.rw, bus.busw, bus.misalignW} !== '0) begin n_fail++;
      $display("FAIL rst_w_port got we=%b rw=%0d busw=%h mis=%b exp all 0", bus.we, bus.rw, bus.busw, bus.misalignW); end
    // Release mid-cycle: state must remain zero until the next edge.
    reset = 1'b1;
    drive_e(1'b1, 1'b0, LT_LW, 32'h1234, 5'd3);
    #2;
    n_chk++; if (bus.RegWriteM !== 1'b0 || bus.Alu_outM !== 32'h0) begin n_fail++;
      $display("FAIL rst_release_midcycle got RegWriteM=%b Alu_outM=%h exp 0/0", bus.RegWriteM, bus.Alu_outM); end
    push_exp(1'b1, 5'd3, 32'h1234, 1'b0, 1'b1);
    tick();
    n_chk++; if ({bus.RegWriteM, bus.rwM, bus.Alu_outM} !== {1'b1, 5'd3, 32'h1234}) begin n_fail++;
      $display("FAIL first_M got RegWriteM=%b rwM=%0d Alu_outM=%h exp 1/3/1234", bus.RegWriteM, bus.rwM, bus.Alu_outM); end
    n_chk++; if (bus.dmem_addr !== 32'h1234) begin n_fail++; $display("FAIL dmem_addr got %h exp 1234", bus.dmem_addr); end
    drive_e(1'b0, 1'b0, LT_LW, 32'h0, 5'd0);
    tick();
    if (exp_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL first_W scoreboard empty"); end
    else begin
      exp_t e = exp_q.pop_front();
      n_chk++; if ({bus.we, bus.rw, bus.busw} !== {e.we, e.rw, e.busw}) begin n_fail++;
        $display("FAIL first_W got we=%b rw=%0d busw=%h exp %b/%0d/%h", bus.we, bus.rw, bus.busw, e.we, e.rw, e.busw); end
    end
  endtask

  task automatic test_load_fwd();
    drive_e(1'b1, 1'b1, LT_LW, 32'h100, 5'd5);
    push_exp(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    tick();
    n_chk++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL load_fwd_RegWriteM got %b exp 0", bus.RegWriteM); end
    n_chk++; if (bus.load_pendingM !== 1'b1) begin n_fail++; $display("FAIL load_pendingM got %b exp 1", bus.load_pendingM); end
    drive_e(1'b0, 1'b0, LT_LW, 32'h0, 5'd0);
    tick();
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    if (exp_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL lw_W scoreboard empty"); end
    else begin
      exp_t e = exp_q.pop_front();
      n_chk++; if ({bus.we, bus.rw, bus.busw, bus.misalignW} !== {e.we, e.rw, e.busw, e.mis}) begin n_fail++;
        $display("FAIL lw_W got we=%b rw=%0d busw=%h mis=%b exp %b/%0d/%h/%b", bus.we, bus.rw, bus.busw, bus.misalignW, e.we, e.rw, e.busw, e.mis); end
    end
  endtask

  // Back-to-back loads: each cycle one enters M while the previous one sits in W.
  task automatic run_loads(input string tag, input logic [31:0] rdata, input logic [2:0] lts[],
                           input logic [31:0] addrs[], input logic [31:0] exps[], input logic miss[]);
    bus.dmem_rdata = rdata;
    for (int i = 0; i <= lts.size(); i++) begin
      if (i < lts.size()) begin
        drive_e(1'b1, 1'b1, lts[i], addrs[i], 5'(10 + i));
        push_exp(~miss[i], 5'(10 + i), exps[i], miss[i], ~miss[i]);
      end else drive_e(1'b0, 1'b0, LT_LW, 32'h0, 5'd0);
      tick();
      if (i >= 1) begin
        if (exp_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL %s scoreboard empty", tag); end
        else begin
          exp_t e = exp_q.pop_front();
          n_chk++; if ({bus.we, bus.rw, bus.misalignW} !== {e.we, e.rw, e.mis}) begin n_fail++;
            $display("FAIL %s[%0d] ctl got we=%b rw=%0d mis=%b exp %b/%0d/%b", tag, i-1, bus.we, bus.rw, bus.misalignW, e.we, e.rw, e.mis); end
          if (e.chk_busw) begin
            n_chk++; if (bus.busw !== e.busw) begin n_fail++;
              $display("FAIL %s[%0d] busw got %h exp %h", tag, i-1, bus.busw, e.busw); end
          end
        end
      end
    end
  endtask

  task automatic test_extension();
    logic [2:0]  lts[]   = '{LT_LB, LT_LBU, LT_LH, LT_LH, LT_LBU, LT_LB};
    logic [31:0] addrs[] = '{32'h200, 32'h201, 32'h202, 32'h200, 32'h203, 32'h202};
    logic [31:0] exps[]  = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'hFFFF_80FF, 32'h0000_0001, 32'h0000_007F};
    logic        miss[]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_loads("ext", 32'h80FF_7F01, lts, addrs, exps, miss);
  endtask

  task automatic test_halfword_unsigned();
    logic [2:0]  lts[]   = '{LT_LHU, LT_LHU, LT_LH, 3'b111};
    logic [31:0] addrs[] = '{32'h300, 32'h302, 32'h302, 32'h304};
    logic [31:0] exps[]  = '{32'h0000_80FF, 32'h0000_8001, 32'hFFFF_8001, 32'h80FF_8001};
    logic        miss[]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_loads("half", 32'h80FF_8001, lts, addrs, exps, miss);
  endtask

  task automatic test_misalign();
    logic [2:0]  lts[]   = '{LT_LW, LT_LH, LT_LHU, LT_LW, LT_LW};
    logic [31:0] addrs[] = '{32'h102, 32'h201, 32'h203, 32'h101, 32'h104};
    logic [31:0] exps[]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1122_3344};
    logic        miss[]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    run_loads("mis", 32'h1122_3344, lts, addrs, exps, miss);
  endtask

  task automatic test_r0();
    drive_e(1'b1, 1'b0, LT_LW, 32'h77, 5'd0);
    push_exp(1'b0, 5'd0, 32'h77, 1'b0, 1'b1);
    tick();
    n_chk++; if (bus.RegWriteM !== 1'b0 || bus.load_pendingM !== 1'b0) begin n_fail++;
      $display("FAIL r0_M got RegWriteM=%b load_pendingM=%b exp 0/0", bus.RegWriteM, bus.load_pendingM); end
    drive_e(1'b1, 1'b1, LT_LW, 32'h80, 5'd0);
    push_exp(1'b0, 5'd0, 32'h1122_3344, 1'b0, 1'b1);
    tick();
    n_chk++; if (bus.load_pendingM !== 1'b0) begin n_fail++; $display("FAIL r0_load_pendingM got %b exp 0", bus.load_pendingM); end
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL r0_W scoreboard empty"); end
      else begin
        exp_t e = exp_q.pop_front();
        n_chk++; if ({bus.we, bus.rw, bus.busw} !== {e.we, e.rw, e.busw}) begin n_fail++;
          $display("FAIL r0_W[%0d] got we=%b rw=%0d busw=%h exp %b/%0d/%h", k, bus.we, bus.rw, bus.busw, e.we, e.rw, e.busw); end
      end
      drive_e(1'b0, 1'b0, LT_LW, 32'h0, 5'd0);
      tick();
    end
  endtask

  task automatic test_stall_flush();
    drive_e(1'b1, 1'b0, LT_LW, 32'hABC, 5'd9);
    push_exp(1'b1, 5'd9, 32'hABC, 1'b0, 1'b1);
    tick();
    bus.stallM = 1'b1;
    drive_e(1'b1, 1'b0, LT_LW, 32'h999, 5'd12);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if ({bus.RegWriteM, bus.rwM, bus.Alu_outM} !== {1'b1, 5'd9, 32'hABC}) begin n_fail++;
        $display("FAIL stall_hold[%0d] got RegWriteM=%b rwM=%0d Alu_outM=%h exp 1/9/abc", k, bus.RegWriteM, bus.rwM, bus.Alu_outM); end
      n_chk++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL stall_we[%0d] got %b exp 0", k, bus.we); end
    end
    bus.stallM = 1'b0;
    push_exp(1'b1, 5'd12, 32'h999, 1'b0, 1'b1);
    tick();
    n_chk++; if (bus.rwM !== 5'd12) begin n_fail++; $display("FAIL unstall_rwM got %0d exp 12", bus.rwM); end
    if (exp_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL unstall_W scoreboard empty"); end
    else begin
      exp_t e = exp_q.pop_front();
      n_chk++; if ({bus.we, bus.rw, bus.busw} !== {e.we, e.rw, e.busw}) begin n_fail++;
        $display("FAIL unstall_W got we=%b rw=%0d busw=%h exp %b/%0d/%h", bus.we, bus.rw, bus.busw, e.we, e.rw, e.busw); end
    end
    // Stall and flush together: flush wins; the rw=12 entry in M is dropped.
    void'(exp_q.pop_front());
    bus.stallM = 1'b1; bus.flushM = 1'b1;
    tick();
    n_chk++; if ({bus.RegWriteM, bus.rwM, bus.Alu_outM} !== '0) begin n_fail++;
      $display("FAIL stall_flush_M got RegWriteM=%b rwM=%0d Alu_outM=%h exp 0/0/0", bus.RegWriteM, bus.rwM, bus.Alu_outM); end
    n_chk++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL stall_flush_we got %b exp 0", bus.we); end
    // Flush alone with a valid E instruction.
    bus.stallM = 1'b0; bus.flushM = 1'b1;
    drive_e(1'b1, 1'b0, LT_LW, 32'h5A5, 5'd4);
    tick();
    n_chk++; if (bus.RegWriteM !== 1'b0 || bus.rwM !== 5'd0) begin n_fail++;
      $display("FAIL flush_M got RegWriteM=%b rwM=%0d exp 0/0", bus.RegWriteM, bus.rwM); end
    bus.flushM = 1'b0;
    drive_e(1'b0, 1'b0, LT_LW, 32'h0, 5'd0);
    tick();
    n_chk++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL flush_W_we got %b exp 0", bus.we); end
  endtask

  initial begin
    test_reset();
    test_load_fwd();
    test_extension();
    test_halfword_unsigned();
    test_misalign();
    test_r0();
    test_stall_flush();
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Producer side of the register-file write and forwarding interface in the 5-stage pipeline.
- Holds the EX/MEM and MEM/WB pipeline registers.
- Drives the M-stage forwarding triple (RegWriteM, Alu_outM, rwM) and the W-stage write port (we, rw, busw) consumed by the register file.
- Aligns and extends load data returned by the synchronous data memory.

Parameters:
- DW, 32, datapath width; must be 32, because load extraction assumes 4 bytes per word.
- AW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- reg_writeE  in  1  EX-stage instruction writes a register.
- mem_to_regE  in  1  EX-stage instruction is a load.
- load_typeE  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others are reserved and treated as LW.
- alu_outE  in  DW  EX result or effective address.
- rwE  in  AW  destination register.
- stallM  in  1  hold the M register.
- flushM  in  1  load a bubble into the M register.
- dmem_rdata  in  DW  word read data, valid in W for the address presented in M.
- dmem_addr  out  DW  equals Alu_outM.
- RegWriteM  out  1  M-stage result is forwardable.
- Alu_outM  out  DW  M-stage ALU result.
- rwM  out  AW  M-stage destination register.
- load_pendingM  out  1  M holds a load to a nonzero register; feeds the hazard unit.
- we  out  1  register-file write enable (W stage).
- rw  out  AW  register-file write address.
- busw  out  DW  register-file write data.
- misalignW  out  1  W holds a misaligned load; its write is suppressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - M and W register fields are all 0.
  - Outputs: RegWriteM=0, Alu_outM=0, rwM=0, load_pendingM=0, we=0, rw=0, busw=0, misalignW=0.
- Latency: E inputs appear on the M outputs 1 cycle later. They appear on we/rw/busw 2 cycles later, absent stalls.
- M register, on posedge, priority order:
  - flushM=1: loads a bubble (reg_write=0, mem_to_reg=0, rw=0, alu_out=0). flushM takes priority over stallM.
  - else stallM=1: holds its contents.
  - else loads the E inputs.
- W register, on posedge:
  - stallM=1 or flushM=1: loads a bubble.
  - else loads the M contents.
- Forwarding outputs:
  - RegWriteM = reg_writeM & ~mem_to_regM & (rwM != 0).
  - Loads are never forwarded from M.
  - Writes to r0 are never forwarded.
- load_pendingM = reg_writeM & mem_to_regM & (rwM != 0).
- Load extraction, combinational in W, from dmem_rdata and alu_outW[1:0], big-endian (byte offset 0 = bits 31:24):
  - LW: whole word; misaligned if offset != 0.
  - LH/LHU: offset 0 selects [31:16], offset 2 selects [15:0]; misaligned if offset[0]=1. LH sign-extends, LHU zero-extends.
  - LB/LBU: byte at offset selected. LB sign-extends, LBU zero-extends.
- W-stage outputs:
  - busw = mem_to_regW ? extracted value : alu_outW.
  - misalignW = mem_to_regW & reg_writeW & misaligned.
  - we = reg_writeW & (rwW != 0) & ~misalignW.
  - rw = rwW.
- Timing: busw is stable for the full cycle after posedge. The register file captures it at negedge, so a same-cycle decode read is bypassed by the file itself.
- Simultaneous events:
  - stallM and flushM together: flush wins.
  - Reset deasserted mid-cycle: state stays zero until the next posedge.

Decomposition:
- Shared package cpu_pkg holds:
  - load_type encodings LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU.
  - The pipeline-bundle typedef {reg_write, mem_to_reg, load_type, alu_out, rw}, used by both the M and W registers.
- One sub-module: load_align (combinational extraction, extension and misalign detection).

Test Plan:
- Reset: hold reset=0 while driving E inputs -> all outputs 0. Release reset; reg_writeE=1, rwE=3, alu_outE=0x1234 -> next cycle RegWriteM=1, rwM=3, Alu_outM=0x1234; cycle after that we=1, rw=3, busw=0x1234.
- Load forwarding block: mem_to_regE=1, rwE=5 -> in M, RegWriteM=0 and load_pendingM=1. In W, with dmem_rdata=0xDEADBEEF, LW at address 0x100 -> busw=0xDEADBEEF, we=1.
- Extension: dmem_rdata=0x80FF7F01, LB at offset 0 -> busw=0xFFFFFF80; LBU at offset 1 -> 0x000000FF; LH at offset 2 -> 0x00007F01; LH at offset 0 -> 0xFFFF80FF.
- Misalign: LW at address 0x102 -> misalignW=1, we=0. LH at offset 1 -> misalignW=1.
- r0 destination: reg_writeE=1, rwE=0 -> RegWriteM=0 and load_pendingM=0; in W, we=0.
- Stall/flush: stallM=1 for 2 cycles -> M outputs held and W shows we=0 in both cycles. stallM=1 with flushM=1 -> M becomes a bubble (RegWriteM=0 next cycle).
